// File: rtl/sha256_message_scheduler.sv
// Purpose: SHA-256 message scheduler; expands one 512-bit block into W[0..63] paired with K[0..63]. Option macro: SHA256_SCHED_BACKPRESSURE_EN.
// Latency: W[0] is valid one cycle after start is sampled; one word per accept; done pulses one cycle after W[63] is accepted.
// Backpressure: with SHA256_SCHED_BACKPRESSURE_EN, out_ready low stalls the window and outputs; without it, every RUN cycle is an accept.
module sha256_message_scheduler (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] block_in,
`ifdef SHA256_SCHED_BACKPRESSURE_EN
    input  logic         out_ready,
`endif
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic         out_valid,
    output logic [5:0]   round,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FIPS 180-4 round constants, indexed by round number.
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t      state;
    logic [31:0] win [16];
    logic [31:0] w_next;
    logic        advance;
    logic        accept;

    // sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

`ifdef SHA256_SCHED_BACKPRESSURE_EN
    assign advance = out_ready;
`else
    assign advance = 1'b1;
`endif

    // out_valid is only ever high in RUN, so it fully qualifies the transfer.
    assign accept = out_valid & advance;

    // Next schedule word: win[0] is W[t], so win[14]/win[9]/win[1] are W[t+14]/W[t+9]/W[t+1].
    assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    // Control FSM, 16-word sliding window and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round     <= '0;
            w_out     <= '0;
            k_out     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= block_in[511 - 32*i -: 32];
                        end
                        round     <= '0;
                        w_out     <= block_in[511:480];
                        k_out     <= K_ROM[0];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[15] <= w_next;
                        if (round == 6'd63) begin
                            // Final word taken: w_out/k_out keep W[63]/K[63] until the next block.
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            round <= round + 6'd1;
                            w_out <= win[1];
                            k_out <= K_ROM[round + 6'd1];
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; it is only sampled in IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_message_scheduler.sv
`timescale 1ns/1ps
module tb_sha256_message_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [511:0] block_in = '0;
    logic         out_ready = 1'b1;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic         out_valid;
    logic [5:0]   round;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    // Reference schedule for the block most recently launched, plus K table.
    logic [31:0] model_w [64];
    logic [31:0] model_k [64];
    int          exp_idx = 0;

    // Words observed per round during the most recent run.
    logic [31:0] cap_w [64];
    logic [31:0] cap_k [64];
    logic [511:0] blk_other = '0;

    sha256_message_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .block_in  (block_in),
`ifdef SHA256_SCHED_BACKPRESSURE_EN
        .out_ready (out_ready),
`endif
        .w_out     (w_out),
        .k_out     (k_out),
        .out_valid (out_valid),
        .round     (round),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %08h required %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook expansion: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
    task automatic set_model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) begin
            model_w[t] = blk[511 - 32*t -: 32];
        end
        for (int t = 16; t < 64; t++) begin
            model_w[t] = ssig1(model_w[t-2]) + model_w[t-7] + ssig0(model_w[t-15]) + model_w[t-16];
        end
    endtask

    task automatic launch(input logic [511:0] blk);
        block_in = blk;
        set_model(blk);
        exp_idx = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Streams one block to completion (or until reset_at), capturing words and counting transfers.
    task automatic run_block(input bit bp, input int start_at, input int reset_at,
                             output int n_valid, output int n_acc, output bit got_done, output bit done_ok);
        bit [3:0] pat = 4'b1001;
        bit last = 1'b0;
        bit injected = 1'b0;
        bit rdy;
        n_valid = 0;
        n_acc = 0;
        got_done = 1'b0;
        done_ok = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                done_ok = last;
                break;
            end
            rdy = 1'b1;
            start = 1'b0;
            last = 1'b0;
            if (out_valid) begin
                if (bp) rdy = pat[cyc % 4];
                n_valid++;
                cap_w[round] = w_out;
                cap_k[round] = k_out;
                if (rdy) n_acc++;
                last = rdy && (round == 6'd63);
                if (start_at >= 0 && int'(round) == start_at && !injected) begin
                    start = 1'b1;
                    block_in = blk_other;
                    injected = 1'b1;
                end
                if (reset_at >= 0 && int'(round) == reset_at) begin
                    reset = 1'b1;
                    out_ready = 1'b1;
                    step();
                    return;
                end
            end
            out_ready = rdy;
            step();
        end
        out_ready = 1'b1;
        chk("run_completes", 32'(got_done), 32'd1);
    endtask

    // Stream checker: every valid cycle must show the next expected W/K/round.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_idx > 63) begin
                chk("valid_after_r63", 32'(out_valid), 32'd0);
            end else begin
                chk("w_stream", w_out, model_w[exp_idx]);
                chk("k_stream", k_out, model_k[exp_idx]);
                chk("round_stream", 32'(round), 32'(exp_idx));
                if (out_ready) exp_idx++;
            end
        end
    end

    initial begin
        int nv, na;
        bit gd, dok;
        logic [511:0] blk_abc, blk_b, blk_c;

        model_k = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };

        blk_abc = '0;
        blk_abc[511:480] = 32'h61626380;
        blk_abc[31:0] = 32'h00000018;
        for (int i = 0; i < 16; i++) begin
            blk_b[511 - 32*i -: 32] = 32'(32'h9e3779b9 * (i + 1)) ^ 32'h5a5a0f0f;
            blk_c[511 - 32*i -: 32] = 32'(32'h01234567 + 32'h11111111 * i);
        end
        blk_other = blk_c;

        // Reset then idle.
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_w_out", w_out, 32'd0);
        chk("idle_k_out", k_out, 32'd0);

        // Pin the model with hand-derived "abc" words.
        set_model(blk_abc);
        chk("model_w16", model_w[16], 32'h61626380);
        chk("model_w17", model_w[17], 32'h000f0000);

        // "abc" block, full rate.
        launch(blk_abc);
        chk("lat1_valid", 32'(out_valid), 32'd1);
        chk("lat1_round", 32'(round), 32'd0);
        chk("lat1_w0", w_out, 32'h61626380);
        chk("lat1_k0", k_out, 32'h428a2f98);
        chk("lat1_busy", 32'(busy), 32'd1);
        run_block(1'b0, -1, -1, nv, na, gd, dok);
        chk("abc_w15", cap_w[15], 32'h00000018);
        chk("abc_w16", cap_w[16], 32'h61626380);
        chk("abc_w17", cap_w[17], 32'h000f0000);
        chk("abc_k17", cap_k[17], 32'hefbe4786);
        chk("abc_k63", cap_k[63], 32'hc67178f2);
        chk("abc_valid_cycles", 32'(nv), 32'd64);
        chk("abc_accepts", 32'(na), 32'd64);
        chk("abc_done_after_r63", 32'(dok), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);

        // start held through DONE (ignored) and into IDLE (taken): back-to-back block.
        block_in = blk_b;
        set_model(blk_b);
        exp_idx = 0;
        start = 1'b1;
        step();
        chk("start_in_done_ignored", 32'(out_valid), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done_busy", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_w0", w_out, 32'hc46d76b6);
        chk("b2b_round", 32'(round), 32'd0);

        // start pulsed at round 20 must not disturb the stream.
        run_block(1'b0, 20, -1, nv, na, gd, dok);
        chk("b_accepts", 32'(na), 32'd64);
        chk("b_done_after_r63", 32'(dok), 32'd1);
        step();
        step();
        chk("idle_hold_w", w_out, model_w[63]);
        chk("idle_hold_k", k_out, 32'hc67178f2);
        chk("idle_hold_valid", 32'(out_valid), 32'd0);

`ifdef SHA256_SCHED_BACKPRESSURE_EN
        // Same block with out_ready pattern 1,0,0,1.
        launch(blk_abc);
        run_block(1'b1, -1, -1, nv, na, gd, dok);
        chk("bp_accepts", 32'(na), 32'd64);
        chk("bp_valid_cycles", 32'(nv), 32'd128);
        chk("bp_w17", cap_w[17], 32'h000f0000);
        chk("bp_k63", cap_k[63], 32'hc67178f2);
        chk("bp_done_after_r63", 32'(dok), 32'd1);
        step();
`endif

        // Reset mid-block at round 30.
        launch(blk_c);
        run_block(1'b0, -1, 30, nv, na, gd, dok);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_round", 32'(round), 32'd0);
        chk("rst_w_out", w_out, 32'd0);
        chk("rst_k_out", k_out, 32'd0);
        reset = 1'b0;
        step();

        // Restart after reset.
        launch(blk_abc);
        chk("restart_w0", w_out, 32'h61626380);
        chk("restart_round", 32'(round), 32'd0);
        run_block(1'b0, -1, -1, nv, na, gd, dok);
        chk("restart_valid_cycles", 32'(nv), 32'd64);
        chk("restart_done_after_r63", 32'(dok), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_message_scheduler.md
SHA256_MESSAGE_SCHEDULER -- requirements
Module: sha256_message_scheduler

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by FIPS 180-4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to load a new block; sampled only in IDLE.
REQ-005 block_in  input  512  padded message block; word 0 = block_in[511:480], word 15 = block_in[31:0].
REQ-006 out_ready  input  1  consumer accepts the current word; present only when SHA256_SCHED_BACKPRESSURE_EN is defined.
REQ-007 w_out  output  32  current schedule word W[t].
REQ-008 k_out  output  32  round constant K[t], always aligned with w_out.
REQ-009 out_valid  output  1  w_out, k_out and round are valid.
REQ-010 round  output  6  index t of the word on w_out.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle pulse after W[63] is accepted.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with these transitions:
- IDLE->RUN on start.
- RUN->DONE when round=63 is accepted.
- DONE->IDLE unconditionally after one cycle.
REQ-014 A transfer ("accept") SHALL occur in a cycle where out_valid=1 and the advance condition holds (REQ-027/028).
REQ-015 On start in IDLE, the block SHALL capture the 16 words of block_in into a 16x32 window win[0..15] and set round=0.
REQ-016 out_valid SHALL rise on the cycle after start is sampled, with w_out=W[0] (latency 1).
REQ-017 In RUN, w_out SHALL equal win[0], k_out SHALL equal K[round], and out_valid SHALL be 1.
REQ-018 On each accept, the window SHALL shift down one word, win[15] SHALL load W[t+16], and round SHALL increment.
- W[t+16] = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32.
REQ-019 sigma0(x) SHALL be ROTR7 ^ ROTR18 ^ SHR3, and sigma1(x) SHALL be ROTR17 ^ ROTR19 ^ SHR10.
REQ-020 K[0..63] SHALL be the 64 FIPS 180-4 constants held in an internal ROM.
REQ-021 When there is no accept in RUN, w_out, k_out, round and the window SHALL hold stable.
REQ-022 round SHALL NOT wrap; acceptance of round 63 ends RUN, and out_valid SHALL be 0 in DONE.
REQ-023 start while busy SHALL be ignored and SHALL NOT change block_in capture or round.
REQ-024 In IDLE, out_valid and done SHALL be 0; w_out and k_out SHALL hold their last values.
REQ-025 A start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; start SHALL be sampled only while in IDLE.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL take the following values, regardless of state or mid-block progress:
- state=IDLE
- round=0, w_out=0, k_out=0
- out_valid=0, busy=0, done=0
- window cleared
- reset SHALL take priority over start.

Configuration
REQ-027 With SHA256_SCHED_BACKPRESSURE_EN defined, port out_ready SHALL exist, and an accept SHALL require out_valid & out_ready.
REQ-028 Without SHA256_SCHED_BACKPRESSURE_EN, port out_ready SHALL be absent, every RUN cycle SHALL be an accept, and a block SHALL take exactly 64 cycles of out_valid.

Verification
REQ-029 Reset, then idle 5 cycles -> out_valid=0, done=0, busy=0, w_out=0, k_out=0.
REQ-030 start with "abc" block (word0=61626380, words1-14=0, word15=00000018), out_ready=1 -> the following SHALL hold:
- round0: w=61626380, k=428a2f98
- round15: w=00000018
- round16: w=61626380
- round17: w=000f0000, k=efbe4786
- round63: k=c67178f2
- done pulses on the cycle after round 63.
REQ-031 Same block, out_ready toggled 1,0,0,1 (BACKPRESSURE_EN) -> w_out, k_out and round hold during the 0 cycles; the sequence is identical to REQ-030.
REQ-032 start pulsed at round 20 -> ignored; the sequence continues unchanged to 63.
REQ-033 reset asserted at round 30 -> next cycle IDLE, out_valid=0; a new start restarts at round 0 with W[0].
REQ-034 Back-to-back blocks: start on the cycle after done -> out_valid returns one cycle later with the new W[0].
